// File: rtl/run_level_scan_pkg.sv
// Shared types, widths and MPEG-2 coefficient scan tables for the run/level scanner.
package run_level_scan_pkg;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned RUN_W   = 6;
    localparam int unsigned POS_W   = 7;
    localparam int unsigned MAX_IDX = 63;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Scan index -> raster address
    localparam logic [ADDR_W-1:0] ZIGZAG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [ADDR_W-1:0] ALTERNATE [64] = '{
        6'd0,  6'd8,  6'd16, 6'd24, 6'd1,  6'd9,  6'd2,  6'd10,
        6'd17, 6'd25, 6'd32, 6'd40, 6'd48, 6'd56, 6'd57, 6'd49,
        6'd41, 6'd33, 6'd26, 6'd18, 6'd3,  6'd11, 6'd4,  6'd12,
        6'd19, 6'd27, 6'd34, 6'd42, 6'd50, 6'd58, 6'd35, 6'd43,
        6'd51, 6'd59, 6'd20, 6'd28, 6'd5,  6'd13, 6'd6,  6'd14,
        6'd21, 6'd29, 6'd36, 6'd44, 6'd52, 6'd60, 6'd37, 6'd45,
        6'd53, 6'd61, 6'd22, 6'd30, 6'd7,  6'd15, 6'd23, 6'd31,
        6'd38, 6'd46, 6'd54, 6'd62, 6'd39, 6'd47, 6'd55, 6'd63
    };

endpackage

// File: rtl/run_level_scan_if.sv
// Token input, idct2d coefficient/control side and status of the run/level scanner.
interface run_level_scan_if;
    import run_level_scan_pkg::*;

    logic                rl_valid;
    logic                rl_ready;
    logic [RUN_W-1:0]    rl_run;
    logic [LEVEL_W-1:0]  rl_level;
    logic                rl_eob;
    logic                alt_scan;
    logic [ADDR_W-1:0]   iaddr;
    logic [LEVEL_W-1:0]  idata;
    logic                iwren;
    logic                idct_en;
    logic                idct_rdy;
    logic                blk_done;
    logic                err;

    modport master (
        output rl_valid, rl_run, rl_level, rl_eob, alt_scan, idct_rdy,
        input  rl_ready, iaddr, idata, iwren, idct_en, blk_done, err
    );

    modport slave (
        input  rl_valid, rl_run, rl_level, rl_eob, alt_scan, idct_rdy,
        output rl_ready, iaddr, idata, iwren, idct_en, blk_done, err
    );

endinterface

// File: rtl/run_level_scan_scan_rom.sv
// Combinational scan-index to raster-address lookup, zigzag or alternate.
module scan_rom
    import run_level_scan_pkg::*;
(
    input  logic [ADDR_W-1:0] idx_i,
    input  logic              alt_i,
    output logic [ADDR_W-1:0] raster_c_o
);

    always_comb begin
        raster_c_o = ZIGZAG[idx_i];
        if (alt_i) begin
            raster_c_o = ALTERNATE[idx_i];
        end
    end

endmodule

// File: rtl/run_level_scan.sv
// Expands run/level/EOB tokens into raster-ordered coefficient writes and
// sequences one idct2d start/finish handshake per block.
module run_level_scan
    import run_level_scan_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    run_level_scan_if.slave   bus
);

    state_e               state_q;
    logic [POS_W-1:0]     pos_q;
    logic                 alt_q;
    logic                 ovf_q;
    logic                 rl_ready_q;
    logic                 iwren_q;
    logic [ADDR_W-1:0]    iaddr_q;
    logic [LEVEL_W-1:0]   idata_q;
    logic                 idct_en_q;
    logic                 blk_done_q;
    logic                 err_q;

    logic                 accept_c;
    logic                 sel_c;
    logic                 overflow_c;
    logic [POS_W-1:0]     target_c;
    logic [ADDR_W-1:0]    raster_c;

    assign accept_c   = bus.rl_valid && rl_ready_q && (state_q == ST_FILL);
    // First token of a block uses the live scan select; later tokens the latched one.
    assign sel_c      = (pos_q == '0) ? bus.alt_scan : alt_q;
    assign target_c   = pos_q + POS_W'(bus.rl_run);
    assign overflow_c = ovf_q || (target_c > POS_W'(MAX_IDX));

    scan_rom u_scan_rom (
        .idx_i      (target_c[ADDR_W-1:0]),
        .alt_i      (sel_c),
        .raster_c_o (raster_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            pos_q      <= '0;
            alt_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rl_ready_q <= 1'b0;
            iwren_q    <= 1'b0;
            iaddr_q    <= '0;
            idata_q    <= '0;
            idct_en_q  <= 1'b0;
            blk_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            iwren_q    <= 1'b0;
            blk_done_q <= 1'b0;
            unique case (state_q)
                ST_FILL: begin
                    rl_ready_q <= bus.idct_rdy;
                    if (accept_c) begin
                        if (pos_q == '0) begin
                            alt_q <= bus.alt_scan;
                        end
                        if (bus.rl_eob) begin
                            pos_q      <= '0;
                            ovf_q      <= 1'b0;
                            rl_ready_q <= 1'b0;
                            idct_en_q  <= 1'b1;
                            state_q    <= ST_START;
                        end else if (overflow_c) begin
                            // Swallow the rest of the block without writing.
                            ovf_q <= 1'b1;
                            err_q <= 1'b1;
                        end else begin
                            iwren_q <= 1'b1;
                            iaddr_q <= raster_c;
                            idata_q <= bus.rl_level;
                            pos_q   <= target_c + POS_W'(1);
                        end
                    end
                end
                ST_START: begin
                    rl_ready_q <= 1'b0;
                    if (!bus.idct_rdy) begin
                        idct_en_q <= 1'b0;
                        state_q   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    rl_ready_q <= 1'b0;
                    if (bus.idct_rdy) begin
                        blk_done_q <= 1'b1;
                        rl_ready_q <= 1'b1;
                        state_q    <= ST_FILL;
                    end
                end
                default: begin
                    rl_ready_q <= 1'b0;
                    state_q    <= ST_FILL;
                end
            endcase
        end
    end

    assign bus.rl_ready = rl_ready_q;
    assign bus.iwren    = iwren_q;
    assign bus.iaddr    = iaddr_q;
    assign bus.idata    = idata_q;
    assign bus.idct_en  = idct_en_q;
    assign bus.blk_done = blk_done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/run_level_scan.md
RUN_LEVEL_SCAN -- requirements
Module: run_level_scan

Interface
REQ-001 clk  input  1  system clock; all state changes on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 rl_valid  input  1  a run/level/EOB token is present.
REQ-004 rl_ready  output  1  block accepts the token this cycle; transfer occurs when rl_valid=1 and rl_ready=1.
REQ-005 rl_run  input  6  count of zero coefficients preceding the level.
REQ-006 rl_level  input  8  coefficient value, two's complement, passed through unchanged.
REQ-007 rl_eob  input  1  token is end-of-block; rl_run and rl_level are ignored.
REQ-008 alt_scan  input  1  0 selects zigzag scan, 1 selects alternate scan; sampled on the first token of each block.
REQ-009 iaddr  output  6  raster coefficient address driven to idct2d.
REQ-010 idata  output  8  coefficient value driven to idct2d.
REQ-011 iwren  output  1  coefficient write strobe to idct2d.
REQ-012 idct_en  output  1  start request to idct2d.
REQ-013 idct_rdy  input  1  idct2d ready (idle) flag.
REQ-014 blk_done  output  1  one-cycle pulse when idct2d finishes a block.
REQ-015 err  output  1  sticky scan-overflow flag.

Function
REQ-016 FSM states: FILL, START, BUSY. Reset state is FILL.
REQ-017 FILL: rl_ready = idct_rdy.
REQ-018 FILL, non-EOB token accepted: target = pos + run, computed 7 bits wide.
  - If target <= 63: on the next cycle drive iwren=1, iaddr=scan[target], idata=level; then pos <= target+1.
REQ-019 FILL, overflow (target > 63): iwren stays 0; err <= 1; remaining non-EOB tokens are consumed with no writes until EOB.
REQ-020 pos is a 7-bit counter; pos=64 after a coefficient written at index 63 is legal. Any later non-EOB token is an overflow per REQ-019.
REQ-021 FILL, EOB accepted: pos <= 0; state -> START. An empty block (EOB at pos=0) still starts idct2d.
REQ-022 START: rl_ready=0; idct_en=1. Hold until idct_rdy samples 0, then go to BUSY.
REQ-023 BUSY: rl_ready=0; idct_en=0. When idct_rdy samples 1: pulse blk_done for one cycle; go to FILL.
REQ-024 idct2d clears its coefficient store between blocks. This block writes only the coefficients carried by tokens.
REQ-025 At most one write per cycle. Write latency is exactly one cycle after acceptance. All outputs are registered.
REQ-026 alt_scan is latched when pos=0 and a token is accepted. It holds for the rest of the block.
REQ-027 err clears only on reset.

Reset
REQ-028 Reset asserted at any time, including mid-block or in BUSY, forces within the same cycle:
  - state=FILL, pos=0;
  - rl_ready=0, iwren=0, iaddr=0, idata=0, idct_en=0, blk_done=0, err=0;
  - latched scan select = zigzag.
REQ-029 After reset deasserts, rl_ready follows idct_rdy on the next clock edge.

Structure
REQ-030 A shared package holds:
  - both 64-entry 6-bit scan tables, ZIGZAG and ALTERNATE (ISO 13818-2);
  - the FSM state enumeration;
  - width constants: ADDR_W=6, LEVEL_W=8.
REQ-031 Sub-module scan_rom maps a 6-bit scan index plus the scan select to a 6-bit raster address, combinationally.

Verification
REQ-032 Zigzag, with idct_rdy=1: tokens (0,5), (1,-3), EOB -> writes iaddr=0 idata=5, then iaddr=8 idata=0xFD; idct_en then rises.
REQ-033 Alternate scan: token (1,7), EOB -> one write, iaddr=8 idata=7. Token (4,2), EOB -> iaddr=1 idata=2.
REQ-034 Overflow: (63,1) then (0,4), EOB -> single write at iaddr=63; err=1; idct_en still asserted.
REQ-035 Handshake: idct_rdy=0 -> rl_ready=0 and no writes. Full START->BUSY->FILL sequence -> exactly one blk_done pulse.
REQ-036 Reset mid-block after two writes -> all outputs 0 and pos=0. The next block's first token (0,9) writes iaddr=0 idata=9.
